// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : issue_ctrl_pkg
//  Purpose : Shared widths, opcode constants, issue FSM states, IQ entry
//            layout and the opcode classifier used by the issue stage.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package issue_ctrl_pkg;

   localparam int INST_WID = 32;
   localparam int ADDR_WID = 32;
   localparam int ROB_WID  = 4;

   // RV32I major opcodes
   localparam logic [6:0] OPCODE_L     = 7'b0000011;
   localparam logic [6:0] OPCODE_S     = 7'b0100011;
   localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
   localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
   localparam logic [6:0] OPCODE_B     = 7'b1100011;
   localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

   typedef enum logic [0:0] {
      ISSUE_RUN   = 1'b0,
      ISSUE_FLUSH = 1'b1
   } issue_state_e;

   typedef enum logic [1:0] {
      CLS_RS      = 2'd0,
      CLS_LSB     = 2'd1,
      CLS_ILLEGAL = 2'd2
   } inst_class_e;

   typedef struct packed {
      logic [INST_WID-1:0] inst;
      logic [ADDR_WID-1:0] pc;
      logic                pre_j;
   } iq_entry_t;

   // Which back-end unit an instruction needs, decided by its major opcode.
   function automatic inst_class_e classify(input logic [6:0] opcode);
      inst_class_e cls;
      case (opcode)
         OPCODE_L, OPCODE_S:                      cls = CLS_LSB;
         OPCODE_CAL, OPCODE_CALI, OPCODE_B,
         OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL,
         OPCODE_JALR:                             cls = CLS_RS;
         default:                                 cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_ctrl_iq.sv
`default_nettype none
// ============================================================================
//  Module  : issue_ctrl_iq
//  Purpose : Instruction queue of the issue stage. Circular buffer whose
//            head/tail pointers carry an extra wrap bit so full and empty are
//            distinguishable without a separate counter.
//  Ports   : clk, rst_n       clock, async active-low reset
//            en               global enable; low freezes the pointers
//            flush            empty the queue (wins over push/pop)
//            push, wdata      write one entry at the tail
//            pop              drop the head entry
//            rdata            current head entry
//            full, empty      occupancy flags from registered pointers
//  Rev     : 1.0  initial release
// ============================================================================
module issue_ctrl_iq #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_WID = $clog2(DEPTH);

   logic [PTR_WID:0] head_q, head_d;
   logic [PTR_WID:0] tail_q, tail_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             mem_we;

   assign empty = (head_q == tail_q);
   assign full  = (head_q[PTR_WID] != tail_q[PTR_WID]) &&
                  (head_q[PTR_WID-1:0] == tail_q[PTR_WID-1:0]);
   assign rdata = mem_q[head_q[PTR_WID-1:0]];

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      mem_we = 1'b0;
      if (en) begin
         if (flush) begin
            head_d = '0;
            tail_d = '0;
         end else begin
            if (push && !full) begin
               tail_d = tail_q + 1'b1;
               mem_we = 1'b1;
            end
            if (pop && !empty) begin
               head_d = head_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Storage needs no reset: entries are only read while the pointers say
   // they are valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[tail_q[PTR_WID-1:0]] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : issue_ctrl
//  Purpose : In-order issue stage between IFetch and the decoder. Buffers
//            fetched instructions, classifies the head, allocates ROB slots,
//            tracks ROB occupancy and stalls when the ROB or the target unit
//            is full. A rollback flushes everything and costs one FLUSH cycle.
//  Ports   : clk, rst_n, rdy, rollback           control
//            if_valid/if_inst/if_pc/if_pre_j     fetch side, if_ready back
//            rob_commit, rs_full, lsb_full       back-end status
//            dec_inst_done, dec_inst, dec_pc,
//            dec_pre_j, dec_rob_pos              registered issue outputs
//  Rev     : 1.0  initial release
// ============================================================================
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int IQ_DEPTH = 4,
   parameter int ROB_SIZE = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rdy,
   input  logic                rollback,
   input  logic                if_valid,
   input  logic [INST_WID-1:0] if_inst,
   input  logic [ADDR_WID-1:0] if_pc,
   input  logic                if_pre_j,
   output logic                if_ready,
   input  logic                rob_commit,
   input  logic                rs_full,
   input  logic                lsb_full,
   output logic                dec_inst_done,
   output logic [INST_WID-1:0] dec_inst,
   output logic [ADDR_WID-1:0] dec_pc,
   output logic                dec_pre_j,
   output logic [ROB_WID-1:0]  dec_rob_pos
);

   localparam logic [ROB_WID:0] ROB_CAP = (ROB_WID+1)'(ROB_SIZE);

   issue_state_e        state_q, state_d;
   logic [ROB_WID-1:0]  rob_tail_q, rob_tail_d;
   logic [ROB_WID:0]    rob_cnt_q, rob_cnt_d;
   logic                dec_inst_done_q, dec_inst_done_d;
   logic [INST_WID-1:0] dec_inst_q, dec_inst_d;
   logic [ADDR_WID-1:0] dec_pc_q, dec_pc_d;
   logic                dec_pre_j_q, dec_pre_j_d;
   logic [ROB_WID-1:0]  dec_rob_pos_q, dec_rob_pos_d;

   iq_entry_t   push_entry;
   iq_entry_t   head_entry;
   logic        iq_full;
   logic        iq_empty;
   logic        iq_push;
   logic        iq_pop;
   inst_class_e head_cls;
   logic        unit_full;
   logic        pop_ok;
   logic        issue;
   logic        commit_eff;

   assign push_entry = '{inst: if_inst, pc: if_pc, pre_j: if_pre_j};

   // No bypass: readiness is a function of registered state and rollback.
   assign if_ready = (state_q == ISSUE_RUN) && !iq_full && !rollback;
   assign iq_push  = rdy && if_valid && if_ready;

   assign head_cls = classify(head_entry.inst[6:0]);

   always_comb begin
      unit_full = 1'b0;
      case (head_cls)
         CLS_RS:  unit_full = rs_full;
         CLS_LSB: unit_full = lsb_full;
         default: unit_full = 1'b0;
      endcase
   end

   // pop_ok covers every issue term; an illegal head is popped but gets no
   // ROB slot and produces no decoder pulse.
   assign pop_ok     = rdy && (state_q == ISSUE_RUN) && !rollback && !iq_empty &&
                       (rob_cnt_q < ROB_CAP) && !unit_full;
   assign issue      = pop_ok && (head_cls != CLS_ILLEGAL);
   assign iq_pop     = pop_ok;
   assign commit_eff = rdy && !rollback && rob_commit && (rob_cnt_q != '0);

   issue_ctrl_iq #(
      .DEPTH (IQ_DEPTH),
      .WIDTH ($bits(iq_entry_t))
   ) u_iq (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rdy),
      .flush (rollback),
      .push  (iq_push),
      .pop   (iq_pop),
      .wdata (push_entry),
      .rdata (head_entry),
      .full  (iq_full),
      .empty (iq_empty)
   );

   always_comb begin
      state_d         = state_q;
      rob_tail_d      = rob_tail_q;
      rob_cnt_d       = rob_cnt_q;
      dec_inst_done_d = dec_inst_done_q;
      dec_inst_d      = dec_inst_q;
      dec_pc_d        = dec_pc_q;
      dec_pre_j_d     = dec_pre_j_q;
      dec_rob_pos_d   = dec_rob_pos_q;

      if (rdy) begin
         if (rollback) begin
            // Entering or extending FLUSH; rollback overrides all traffic.
            state_d         = ISSUE_FLUSH;
            rob_tail_d      = '0;
            rob_cnt_d       = '0;
            dec_inst_done_d = 1'b0;
         end else begin
            state_d         = ISSUE_RUN;
            dec_inst_done_d = issue;
            if (issue) begin
               dec_inst_d    = head_entry.inst;
               dec_pc_d      = head_entry.pc;
               dec_pre_j_d   = head_entry.pre_j;
               dec_rob_pos_d = rob_tail_q;
               rob_tail_d    = rob_tail_q + 1'b1;   // wraps since ROB_SIZE == 2**ROB_WID
            end
            if (issue && !commit_eff) begin
               rob_cnt_d = rob_cnt_q + 1'b1;
            end else if (!issue && commit_eff) begin
               rob_cnt_d = rob_cnt_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ISSUE_RUN;
         rob_tail_q      <= '0;
         rob_cnt_q       <= '0;
         dec_inst_done_q <= 1'b0;
         dec_inst_q      <= '0;
         dec_pc_q        <= '0;
         dec_pre_j_q     <= 1'b0;
         dec_rob_pos_q   <= '0;
      end else begin
         state_q         <= state_d;
         rob_tail_q      <= rob_tail_d;
         rob_cnt_q       <= rob_cnt_d;
         dec_inst_done_q <= dec_inst_done_d;
         dec_inst_q      <= dec_inst_d;
         dec_pc_q        <= dec_pc_d;
         dec_pre_j_q     <= dec_pre_j_d;
         dec_rob_pos_q   <= dec_rob_pos_d;
      end
   end

   assign dec_inst_done = dec_inst_done_q;
   assign dec_inst      = dec_inst_q;
   assign dec_pc        = dec_pc_q;
   assign dec_pre_j     = dec_pre_j_q;
   assign dec_rob_pos   = dec_rob_pos_q;

endmodule
`default_nettype wire
